uart_tick_gen: RTL and testbench

- Parametrised successor to the fixed-baud clock divider.
- Produces single-cycle enable strobes instead of derived clocks: RX oversample tick, TX bit tick and a 1 kHz / 100 Hz / 1 Hz timebase, all in the CLK_50M domain.
- Baud divisor is run-time programmable with glitch-free switch-over; RX phase can be resynchronised on a start-bit edge.
- Feeds the UART RX/TX engines and the display/debounce timers.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tick_counter.sv | 30 +++
 rtl/uart_tick_gen.sv | 126 ++++++++++++
 tb/tb_uart_tick_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART timing slice.
package uart_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int OS_DEFAULT     = 5;

  localparam int DIV_500K   = 20;
  localparam int DIV_115200 = 87;
  localparam int DIV_19200  = 521;

  // A divisor below 2 would make the RX tick continuous, so it is floored at 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Modulo-MAX event counter with a registered one-cycle wrap strobe.
module tick_counter #(
  parameter int MAX = 10,
  parameter int W   = $clog2(MAX)
) (
  input  logic         CLK_50M,
  input  logic         RST_N,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] CNT,
  output logic         WRAP
);

  logic w_term;
  assign w_term = (CNT == W'(MAX - 1));

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      CNT  <= '0;
      WRAP <= 1'b0;
    end else if (CLR) begin
      CNT  <= '0;
      WRAP <= 1'b0;
    end else begin
      WRAP <= INC && w_term;
      if (INC) CNT <= w_term ? '0 : CNT + W'(1);
    end
  end

endmodule

// File: rtl/uart_tick_gen.sv
// Enable-strobe generator: programmable RX/TX baud ticks plus a 1 kHz/100 Hz/1 Hz timebase.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int OVERSAMPLE  = OS_DEFAULT,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = DIV_500K
) (
  input  logic             CLK_50M,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             DIV_WR,
  input  logic [DIV_W-1:0] DIV_IN,
  input  logic             RX_RESYNC,
  output logic [DIV_W-1:0] DIV_ACTIVE,
  output logic             RX_TICK,
  output logic             TX_TICK,
  output logic             TICK_1K,
  output logic             TICK_100,
  output logic             TICK_1
);

  localparam int TX_W  = DIV_W + 4;
  localparam int PRE   = CLK_HZ / 1000;
  localparam int PRE_W = $clog2(PRE);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pend;
  logic             r_pend_vld;
  logic [DIV_W-1:0] r_rx_cnt;
  logic [TX_W-1:0]  r_tx_cnt;
  logic             r_rx_tick;
  logic             r_tx_tick;

  logic [TX_W-1:0]  w_tx_period;
  logic             w_rx_term;
  logic             w_tx_term;
  logic             w_apply;

  assign w_tx_period = TX_W'(r_div) * TX_W'(OVERSAMPLE);
  assign w_rx_term   = (r_rx_cnt == r_div - DIV_W'(1));
  assign w_tx_term   = (r_tx_cnt == w_tx_period - TX_W'(1));
  // Switching only on a TX boundary keeps every issued bit period whole.
  assign w_apply     = r_pend_vld && (EN ? w_tx_term : 1'b1);

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_div      <= DIV_W'(DEFAULT_DIV);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_rx_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_rx_tick  <= 1'b0;
      r_tx_tick  <= 1'b0;
    end else begin
      if (DIV_WR) begin
        r_pend     <= DIV_W'(clamp_div(32'(DIV_IN)));
        r_pend_vld <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end
      if (w_apply) r_div <= r_pend;

      if (!EN) begin
        r_rx_cnt  <= '0;
        r_tx_cnt  <= '0;
        r_rx_tick <= 1'b0;
        r_tx_tick <= 1'b0;
      end else begin
        r_tx_tick <= w_tx_term;
        r_tx_cnt  <= w_tx_term ? '0 : r_tx_cnt + TX_W'(1);
        if (RX_RESYNC) begin
          r_rx_cnt  <= '0;
          r_rx_tick <= 1'b0;
        end else begin
          r_rx_tick <= w_rx_term;
          r_rx_cnt  <= w_rx_term ? '0 : r_rx_cnt + DIV_W'(1);
        end
        if (w_apply) r_rx_cnt <= '0;
      end
    end
  end

  assign DIV_ACTIVE = r_div;
  assign RX_TICK    = r_rx_tick;
  assign TX_TICK    = r_tx_tick;

  logic [PRE_W-1:0] w_p_cnt;
  logic [3:0]       w_c100_cnt;
  logic [6:0]       w_c1_cnt_unused;
  logic             w_p_term;
  logic             w_c100_inc_term;

  // Chained counters advance on the prescaler's terminal count so all three strobes land together.
  assign w_p_term        = (w_p_cnt == PRE_W'(PRE - 1));
  assign w_c100_inc_term = w_p_term && (w_c100_cnt == 4'd9);

  tick_counter #(.MAX(PRE), .W(PRE_W)) u_p_cnt (
    .CLK_50M (CLK_50M),
    .RST_N   (RST_N),
    .CLR     (1'b0),
    .INC     (1'b1),
    .CNT     (w_p_cnt),
    .WRAP    (TICK_1K)
  );

  tick_counter #(.MAX(10), .W(4)) u_c100 (
    .CLK_50M (CLK_50M),
    .RST_N   (RST_N),
    .CLR     (1'b0),
    .INC     (w_p_term),
    .CNT     (w_c100_cnt),
    .WRAP    (TICK_100)
  );

  tick_counter #(.MAX(100), .W(7)) u_c1 (
    .CLK_50M (CLK_50M),
    .RST_N   (RST_N),
    .CLR     (1'b0),
    .INC     (w_c100_inc_term),
    .CNT     (w_c1_cnt_unused),
    .WRAP    (TICK_1)
  );

endmodule

// File: tb/tb_uart_tick_gen.sv
// Scoreboard bench for uart_tick_gen: expected tick cycles are queued up front and matched as ticks appear.
module tb_uart_tick_gen;

  localparam int CLK_HZ = 50_000;
  localparam int OS     = 5;
  localparam int DIV_W  = 16;
  localparam int PRE    = CLK_HZ / 1000;

  logic             CLK_50M = 1'b0;
  logic             RST_N   = 1'b0;
  logic             EN      = 1'b0;
  logic             DIV_WR  = 1'b0;
  logic [DIV_W-1:0] DIV_IN  = '0;
  logic             RX_RESYNC = 1'b0;
  logic [DIV_W-1:0] DIV_ACTIVE;
  logic             RX_TICK, TX_TICK, TICK_1K, TICK_100, TICK_1;

  uart_tick_gen #(
    .CLK_HZ(CLK_HZ), .OVERSAMPLE(OS), .DIV_W(DIV_W), .DEFAULT_DIV(20)
  ) dut (
    .CLK_50M    (CLK_50M),
    .RST_N      (RST_N),
    .EN         (EN),
    .DIV_WR     (DIV_WR),
    .DIV_IN     (DIV_IN),
    .RX_RESYNC  (RX_RESYNC),
    .DIV_ACTIVE (DIV_ACTIVE),
    .RX_TICK    (RX_TICK),
    .TX_TICK    (TX_TICK),
    .TICK_1K    (TICK_1K),
    .TICK_100   (TICK_100),
    .TICK_1     (TICK_1)
  );

  always #5 CLK_50M = ~CLK_50M;

  // Number of rising edges since the last reset release.
  int cyc;
  always @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  int q_rx[$], q_tx[$], q_1k[$], q_100[$], q_1[$];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic string tag_of(input int w);
    case (w)
      0: return "rx_tick";
      1: return "tx_tick";
      2: return "tick_1k";
      3: return "tick_100";
      default: return "tick_1";
    endcase
  endfunction

  function automatic int qsz(input int w);
    case (w)
      0: return q_rx.size();
      1: return q_tx.size();
      2: return q_1k.size();
      3: return q_100.size();
      default: return q_1.size();
    endcase
  endfunction

  function automatic int qfr(input int w);
    case (w)
      0: return q_rx[0];
      1: return q_tx[0];
      2: return q_1k[0];
      3: return q_100[0];
      default: return q_1[0];
    endcase
  endfunction

  task automatic qpop(input int w);
    case (w)
      0: void'(q_rx.pop_front());
      1: void'(q_tx.pop_front());
      2: void'(q_1k.pop_front());
      3: void'(q_100.pop_front());
      default: void'(q_1.pop_front());
    endcase
  endtask

  task automatic qpush(input int w, input int v);
    case (w)
      0: q_rx.push_back(v);
      1: q_tx.push_back(v);
      2: q_1k.push_back(v);
      3: q_100.push_back(v);
      default: q_1.push_back(v);
    endcase
  endtask

  task automatic push_series(input int w, input int first, input int step, input int last);
    for (int t = first; t <= last; t += step) qpush(w, t);
  endtask

  task automatic push_slow(input int last);
    push_series(2, PRE, PRE, last);
    push_series(3, 10 * PRE, 10 * PRE, last);
    push_series(4, 1000 * PRE, 1000 * PRE, last);
  endtask

  task automatic mon_q(input int w, input logic t);
    while (qsz(w) > 0 && qfr(w) < cyc) begin
      check_val({tag_of(w), "_missed"}, cyc, qfr(w));
      qpop(w);
    end
    if (t) begin
      if (qsz(w) == 0) check_val({tag_of(w), "_extra"}, cyc, -1);
      else begin
        check_val(tag_of(w), cyc, qfr(w));
        if (qfr(w) == cyc) qpop(w);
      end
    end
  endtask

  always @(negedge CLK_50M) begin
    if (mon_en) begin
      mon_q(0, RX_TICK);
      mon_q(1, TX_TICK);
      mon_q(2, TICK_1K);
      mon_q(3, TICK_100);
      mon_q(4, TICK_1);
    end
  end

  // Returns at the falling edge where cyc == k; inputs set here are sampled at edge k+1.
  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge CLK_50M);
  endtask

  task automatic div_write(input int k, input int v);
    wait_cyc(k - 1);
    DIV_IN = DIV_W'(v);
    DIV_WR = 1'b1;
    wait_cyc(k);
    DIV_WR = 1'b0;
  endtask

  task automatic resync_at(input int k);
    wait_cyc(k - 1);
    RX_RESYNC = 1'b1;
    wait_cyc(k);
    RX_RESYNC = 1'b0;
  endtask

  task automatic en_set(input int k, input logic v);
    wait_cyc(k - 1);
    EN = v;
  endtask

  task automatic clear_queues();
    q_rx.delete(); q_tx.delete(); q_1k.delete(); q_100.delete(); q_1.delete();
  endtask

  task automatic start_phase(input logic en_v);
    mon_en = 1'b0;
    RST_N = 1'b0;
    EN = en_v; DIV_WR = 1'b0; RX_RESYNC = 1'b0; DIV_IN = '0;
    clear_queues();
    repeat (3) @(negedge CLK_50M);
    RST_N = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic end_phase(input int n);
    wait_cyc(n);
    #1;
    for (int w = 0; w < 5; w++) check_val({tag_of(w), "_left"}, qsz(w), 0);
  endtask

  initial begin
    // Reset state
    RST_N = 1'b0;
    repeat (2) @(negedge CLK_50M);
    check_val("rst_rx_tick", RX_TICK, 0);
    check_val("rst_tx_tick", TX_TICK, 0);
    check_val("rst_tick_1k", TICK_1K, 0);
    check_val("rst_div", DIV_ACTIVE, 20);

    // Defaults over a full 1 Hz period
    start_phase(1'b1);
    push_series(0, 20, 20, 50000);
    push_series(1, 100, 100, 50000);
    push_slow(50000);
    end_phase(50000);

    // Divisor change applied at TX boundaries, with overwrite and write-on-apply
    start_phase(1'b1);
    push_series(0, 20, 20, 200);
    push_series(0, 287, 87, 635);
    push_series(0, 655, 20, 700);
    qpush(1, 100); qpush(1, 200); qpush(1, 635);
    push_slow(700);
    div_write(120, 521);
    div_write(130, 87);
    wait_cyc(199);
    check_val("div_before_apply", DIV_ACTIVE, 20);
    div_write(200, 20);
    check_val("div_after_apply", DIV_ACTIVE, 87);
    wait_cyc(634);
    check_val("div_second_pend", DIV_ACTIVE, 87);
    wait_cyc(635);
    check_val("div_second_apply", DIV_ACTIVE, 20);
    end_phase(700);

    // RX resync, including one coincident with a terminal count
    start_phase(1'b1);
    qpush(0, 20); qpush(0, 53); qpush(0, 73); qpush(0, 113); qpush(0, 133);
    qpush(1, 100);
    push_slow(140);
    resync_at(33);
    resync_at(93);
    end_phase(140);

    // Clamp of 0 and 1 while disabled, then fastest ticks
    start_phase(1'b0);
    push_series(0, 21, 2, 60);
    push_series(1, 29, 10, 60);
    push_slow(60);
    div_write(3, 87);
    wait_cyc(4);
    check_val("div_en0_87", DIV_ACTIVE, 87);
    div_write(5, 0);
    wait_cyc(6);
    check_val("div_clamp0", DIV_ACTIVE, 2);
    div_write(8, 87);
    wait_cyc(9);
    check_val("div_en0_87b", DIV_ACTIVE, 87);
    div_write(10, 1);
    wait_cyc(11);
    check_val("div_clamp1", DIV_ACTIVE, 2);
    en_set(20, 1'b1);
    end_phase(60);

    // EN dropped for 7 cycles
    start_phase(1'b1);
    push_series(0, 20, 20, 140);
    push_series(0, 176, 20, 260);
    qpush(1, 100); qpush(1, 256);
    push_slow(260);
    en_set(150, 1'b0);
    en_set(157, 1'b1);
    end_phase(260);

    // Mid-period reset discards a pending divisor
    start_phase(1'b1);
    push_series(0, 20, 20, 80);
    push_slow(80);
    div_write(50, 521);
    wait_cyc(80);
    #1;
    RST_N = 1'b0;
    mon_en = 1'b0;
    #1;
    check_val("midrst_rx_tick", RX_TICK, 0);
    check_val("midrst_tx_tick", TX_TICK, 0);
    check_val("midrst_div", DIV_ACTIVE, 20);
    check_val("midrst_rx_left", qsz(0), 0);
    clear_queues();
    push_series(0, 20, 20, 210);
    qpush(1, 100); qpush(1, 200);
    push_slow(210);
    @(negedge CLK_50M);
    RST_N = 1'b1;
    mon_en = 1'b1;
    wait_cyc(205);
    check_val("midrst_div_kept", DIV_ACTIVE, 20);
    end_phase(210);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
